l2_pending_miss_tracker: RTL and testbench

Parametrised pending-miss tracker for the L2 pipeline. It sits at the L2 read stage, beside the system memory request queue. It records every line with an outstanding system memory load, flags later requests to the same line as duplicates, and counts how many requests merged onto each miss. It frees the entry when the fill returns, and provides occupancy/full back-pressure and sticky protocol-error flags so upstream stalls instead of overflowing.

---
 rtl/l2_pending_miss_tracker.sv | 167 ++++++++++++++++
 tb/tb_l2_pending_miss_tracker.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/l2_pending_miss_tracker.sv
// rtl/l2_pending_miss_tracker.sv - CAM of lines with an outstanding system memory load, with merge counts and back-pressure.
// Optional statistics counters are enabled with the L2_PENDING_MISS_STATS_EN macro.
module l2_pending_miss_tracker #(
    parameter int NUM_ENTRIES  = 16,
    parameter int ADDR_WIDTH   = 26,
    parameter int WAITER_WIDTH = 4,
    parameter int INDEX_WIDTH  = $clog2(NUM_ENTRIES),
    parameter int COUNT_WIDTH  = $clog2(NUM_ENTRIES + 1)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    req_valid,
    input  logic [ADDR_WIDTH-1:0]   req_address,
    input  logic                    req_enqueue_load,
    input  logic                    req_is_fill,
    output logic                    duplicate_request,
    output logic [INDEX_WIDTH-1:0]  hit_index,
    output logic [WAITER_WIDTH-1:0] fill_waiters,
    output logic [COUNT_WIDTH-1:0]  occupancy,
    output logic                    full,
    output logic                    almost_full,
    output logic                    err_overflow,
    output logic                    err_orphan_fill
`ifdef L2_PENDING_MISS_STATS_EN
    ,
    output logic [31:0]             stat_misses,
    output logic [31:0]             stat_merges
`endif
);

    logic [NUM_ENTRIES-1:0]  valid_q, valid_d;
    logic [ADDR_WIDTH-1:0]   addr_q    [NUM_ENTRIES];
    logic [ADDR_WIDTH-1:0]   addr_d    [NUM_ENTRIES];
    logic [WAITER_WIDTH-1:0] waiters_q [NUM_ENTRIES];
    logic [WAITER_WIDTH-1:0] waiters_d [NUM_ENTRIES];
    logic [COUNT_WIDTH-1:0]  occupancy_q, occupancy_d;
    logic                    full_q, full_d;
    logic                    almost_full_q, almost_full_d;
    logic                    err_overflow_q, err_overflow_d;
    logic                    err_orphan_fill_q, err_orphan_fill_d;

    logic [NUM_ENTRIES-1:0]  match_vec;
    logic                    hit;
    logic [INDEX_WIDTH-1:0]  hit_idx;
    logic [WAITER_WIDTH-1:0] hit_waiters;
    logic [INDEX_WIDTH-1:0]  free_idx;
    logic                    do_alloc, do_merge, do_free, do_overflow, do_orphan;

    // Parallel lookup; the downward scan leaves the lowest matching index.
    always_comb begin
        match_vec   = '0;
        hit_idx     = '0;
        hit_waiters = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            match_vec[i] = valid_q[i] && (addr_q[i] == req_address);
        end
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (match_vec[i]) begin
                hit_idx     = INDEX_WIDTH'(i);
                hit_waiters = waiters_q[i];
            end
        end
        hit = |match_vec;
    end

    always_comb begin
        free_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_idx = INDEX_WIDTH'(i);
            end
        end
    end

    // A fill always wins over a simultaneous enqueue on the same request.
    always_comb begin
        do_free     = req_valid &&  hit &&  req_is_fill;
        do_merge    = req_valid &&  hit && !req_is_fill && req_enqueue_load;
        do_alloc    = req_valid && !hit && !req_is_fill && req_enqueue_load && !full_q;
        do_overflow = req_valid && !hit && !req_is_fill && req_enqueue_load &&  full_q;
        do_orphan   = req_valid && !hit &&  req_is_fill;
    end

    always_comb begin
        valid_d           = valid_q;
        addr_d            = addr_q;
        waiters_d         = waiters_q;
        occupancy_d       = occupancy_q;
        err_overflow_d    = err_overflow_q    | do_overflow;
        err_orphan_fill_d = err_orphan_fill_q | do_orphan;
        if (do_alloc) begin
            valid_d[free_idx]   = 1'b1;
            addr_d[free_idx]    = req_address;
            waiters_d[free_idx] = '0;
            occupancy_d         = occupancy_q + COUNT_WIDTH'(1);
        end
        if (do_merge && (waiters_q[hit_idx] != {WAITER_WIDTH{1'b1}})) begin
            waiters_d[hit_idx] = waiters_q[hit_idx] + WAITER_WIDTH'(1);
        end
        if (do_free) begin
            valid_d[hit_idx] = 1'b0;
            occupancy_d      = occupancy_q - COUNT_WIDTH'(1);
        end
        full_d        = (occupancy_d == COUNT_WIDTH'(NUM_ENTRIES));
        almost_full_d = (occupancy_d >= COUNT_WIDTH'(NUM_ENTRIES - 1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q           <= '0;
            occupancy_q       <= '0;
            full_q            <= 1'b0;
            almost_full_q     <= 1'b0;
            err_overflow_q    <= 1'b0;
            err_orphan_fill_q <= 1'b0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                addr_q[i]    <= '0;
                waiters_q[i] <= '0;
            end
        end else begin
            valid_q           <= valid_d;
            addr_q            <= addr_d;
            waiters_q         <= waiters_d;
            occupancy_q       <= occupancy_d;
            full_q            <= full_d;
            almost_full_q     <= almost_full_d;
            err_overflow_q    <= err_overflow_d;
            err_orphan_fill_q <= err_orphan_fill_d;
        end
    end

`ifdef L2_PENDING_MISS_STATS_EN
    logic [31:0] stat_misses_q, stat_misses_d;
    logic [31:0] stat_merges_q, stat_merges_d;

    always_comb begin
        stat_misses_d = stat_misses_q + (do_alloc ? 32'd1 : 32'd0);
        stat_merges_d = stat_merges_q + (do_merge ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_misses_q <= '0;
            stat_merges_q <= '0;
        end else begin
            stat_misses_q <= stat_misses_d;
            stat_merges_q <= stat_merges_d;
        end
    end

    assign stat_misses = stat_misses_q;
    assign stat_merges = stat_merges_q;
`endif

    // Lookup outputs are forced low during reset so upstream never sees a stale hit.
    assign duplicate_request = reset_n && hit;
    assign hit_index         = reset_n ? hit_idx : '0;
    assign fill_waiters      = reset_n ? hit_waiters : '0;
    assign occupancy         = occupancy_q;
    assign full              = full_q;
    assign almost_full       = almost_full_q;
    assign err_overflow      = err_overflow_q;
    assign err_orphan_fill   = err_orphan_fill_q;

    a_single_match: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(match_vec));

endmodule

// File: tb/tb_l2_pending_miss_tracker.sv
// tb/tb_l2_pending_miss_tracker.sv - directed plus randomized check of the pending-miss tracker against a map-based model.
module tb_l2_pending_miss_tracker;

    localparam int NE   = 16;
    localparam int AW   = 26;
    localparam int WW   = 4;
    localparam int IW   = $clog2(NE);
    localparam int CW   = $clog2(NE + 1);
    localparam int WMAX = (1 << WW) - 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req_valid;
    logic [AW-1:0] req_address;
    logic          req_enqueue_load;
    logic          req_is_fill;
    logic          duplicate_request;
    logic [IW-1:0] hit_index;
    logic [WW-1:0] fill_waiters;
    logic [CW-1:0] occupancy;
    logic          full;
    logic          almost_full;
    logic          err_overflow;
    logic          err_orphan_fill;
`ifdef L2_PENDING_MISS_STATS_EN
    logic [31:0]   stat_misses;
    logic [31:0]   stat_merges;
`endif

    always #5 clk = ~clk;

    l2_pending_miss_tracker #(
        .NUM_ENTRIES(NE), .ADDR_WIDTH(AW), .WAITER_WIDTH(WW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_address(req_address),
        .req_enqueue_load(req_enqueue_load), .req_is_fill(req_is_fill),
        .duplicate_request(duplicate_request), .hit_index(hit_index),
        .fill_waiters(fill_waiters), .occupancy(occupancy),
        .full(full), .almost_full(almost_full),
        .err_overflow(err_overflow), .err_orphan_fill(err_orphan_fill)
`ifdef L2_PENDING_MISS_STATS_EN
        , .stat_misses(stat_misses), .stat_merges(stat_merges)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: line address -> slot, line address -> merge count, slot occupancy map.
    int  pend [bit [AW-1:0]];
    int  wcnt [bit [AW-1:0]];
    bit  used [NE];
    bit  m_ovf, m_orph;
    longint m_misses, m_merges;
    logic [AW-1:0] pool [20];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        pend.delete();
        wcnt.delete();
        for (int i = 0; i < NE; i++) used[i] = 1'b0;
        m_ovf = 0; m_orph = 0; m_misses = 0; m_merges = 0;
    endtask

    task automatic check_outputs(input logic [AW-1:0] a);
        bit h;
        h = pend.exists(a);
        chk("duplicate_request", duplicate_request, h);
        chk("hit_index", hit_index, h ? pend[a] : 0);
        chk("fill_waiters", fill_waiters, h ? wcnt[a] : 0);
        chk("occupancy", occupancy, pend.num());
        chk("full", full, pend.num() == NE);
        chk("almost_full", almost_full, pend.num() >= NE - 1);
        chk("err_overflow", err_overflow, m_ovf);
        chk("err_orphan_fill", err_orphan_fill, m_orph);
`ifdef L2_PENDING_MISS_STATS_EN
        chk("stat_misses", stat_misses, m_misses & 64'hFFFF_FFFF);
        chk("stat_merges", stat_merges, m_merges & 64'hFFFF_FFFF);
`endif
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input bit v, input logic [AW-1:0] a, input bit e, input bit f);
        bit h;
        req_valid = v; req_address = a; req_enqueue_load = e; req_is_fill = f;
        #1;
        check_outputs(a);
        h = pend.exists(a);
        @(posedge clk);
        if (v) begin
            if (f) begin
                if (h) begin
                    used[pend[a]] = 1'b0;
                    pend.delete(a);
                    wcnt.delete(a);
                end else m_orph = 1;
            end else if (e) begin
                if (h) begin
                    if (wcnt[a] < WMAX) wcnt[a] = wcnt[a] + 1;
                    m_merges++;
                end else if (pend.num() == NE) m_ovf = 1;
                else begin
                    int s;
                    s = 0;
                    while (used[s]) s++;
                    used[s] = 1'b1;
                    pend[a] = s;
                    wcnt[a] = 0;
                    m_misses++;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic peek(input logic [AW-1:0] a);
        req_valid = 0; req_address = a; req_enqueue_load = 0; req_is_fill = 0;
        #1;
    endtask

    task automatic reset_now(input logic [AW-1:0] a);
        req_valid = 1; req_address = a; req_enqueue_load = 1; req_is_fill = 0;
        reset_n = 0;
        #1;
        chk("rst_dup", duplicate_request, 0);
        chk("rst_hit_index", hit_index, 0);
        chk("rst_fill_waiters", fill_waiters, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_full", full, 0);
        chk("rst_almost_full", almost_full, 0);
        chk("rst_err_overflow", err_overflow, 0);
        chk("rst_err_orphan", err_orphan_fill, 0);
        model_reset();
        @(negedge clk);
        req_valid = 0;
        reset_n = 1;
        #1;
    endtask

    initial begin
        reset_n = 0; req_valid = 0; req_address = '0; req_enqueue_load = 0; req_is_fill = 0;
        model_reset();
        for (int k = 0; k < 20; k++) pool[k] = AW'(k * 32'h0013_579B + 32'h100);
        @(negedge clk);
        reset_now(26'h000100);

        // First miss allocates entry 0 and is visible the next cycle.
        step(1, 26'h000100, 1, 0);
        peek(26'h000100);
        chk("plan_occ1", occupancy, 1);
        chk("plan_idx0", hit_index, 0);
        chk("plan_dup", duplicate_request, 1);
        for (int i = 0; i < 3; i++) step(1, 26'h000100, 1, 0);
        peek(26'h000100);
        chk("plan_waiters3", fill_waiters, 3);
        step(1, 26'h000100, 0, 1);
        chk("plan_occ0", occupancy, 0);

        // Fill to capacity, then overflow.
        for (int i = 0; i < NE; i++) begin
            step(1, AW'(32'h1000 + i), 1, 0);
            if (i == NE - 2) chk("plan_almost_full15", almost_full, 1);
            if (i == NE - 2) chk("plan_not_full15", full, 0);
        end
        chk("plan_full", full, 1);
        step(1, 26'h0FFFFF, 1, 0);
        chk("plan_overflow", err_overflow, 1);
        chk("plan_occ16", occupancy, NE);

        // Freed slots are reused lowest first.
        step(1, 26'h001009, 0, 1);
        step(1, 26'h001005, 0, 1);
        step(1, 26'h002000, 1, 0);
        step(1, 26'h002001, 1, 0);
        peek(26'h002000);
        chk("plan_reuse5", hit_index, 5);
        peek(26'h002001);
        chk("plan_reuse9", hit_index, 9);

        // Merge saturation, orphan fill, then reset with lines pending.
        for (int i = 0; i < WMAX + 2; i++) step(1, 26'h001003, 1, 0);
        peek(26'h001003);
        chk("plan_saturate", fill_waiters, WMAX);
        step(1, 26'h3FFFFFF, 0, 1);
        chk("plan_orphan", err_orphan_fill, 1);
        chk("plan_orphan_occ", occupancy, NE);
        @(negedge clk);
        reset_now(26'h001000);

        // Randomized traffic over a small line pool so hits, overflow and orphans all occur.
        for (int n = 0; n < 2500; n++) begin
            int kind;
            logic [AW-1:0] a;
            kind = $urandom_range(0, 9);
            a = pool[$urandom_range(0, 19)];
            if (n == 1200) begin
                @(negedge clk);
                reset_now(a);
            end
            step($urandom_range(0, 9) != 0, a, (kind <= 4) || (kind == 8), (kind >= 5) && (kind <= 8));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
